// File: rtl/intersection_traffic_model.sv
// Sim-harness model of three lane queues driven by the traffic controller's lights; feeds sensors back.
// Optional sequence/conflict checker enabled by defining TLC_SAFETY_CHECK_EN.

package light_package;
   typedef enum logic [1:0] {red, yellow, green} colors;
endpackage

module intersection_traffic_model
   import light_package::*;
#(
   parameter int QDEPTH      = 15,
   parameter int START_DELAY = 2,
   parameter int QW          = $clog2(QDEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ew_str_arrive,
   input  logic          ew_left_arrive,
   input  logic          ns_arrive,
   input  colors         ew_str_light,
   input  colors         ew_left_light,
   input  colors         ns_light,
   output logic          ew_str_sensor,
   output logic          ew_left_sensor,
   output logic          ns_sensor,
   output logic [QW-1:0] ew_str_count,
   output logic [QW-1:0] ew_left_count,
   output logic [QW-1:0] ns_count,
   output logic [15:0]   departed_total,
   output logic [2:0]    dropped,
   output logic [1:0]    safety_err
);

   typedef enum logic [1:0] {STOP, START, FLOW} lane_state_t;

   localparam int NL = 3;  // lane index: 0 ew_str, 1 ew_left, 2 ns

   colors            light [NL];
   logic [NL-1:0]    arrive;
   logic [NL-1:0]    depart;
   logic [NL-1:0]    drop;

   lane_state_t      state_q [NL];
   lane_state_t      state_d [NL];
   logic [3:0]       ctr_q   [NL];
   logic [3:0]       ctr_d   [NL];
   logic [QW-1:0]    count_q [NL];
   logic [QW-1:0]    count_d [NL];
   logic [15:0]      total_q;
   logic [15:0]      total_d;
   logic [NL-1:0]    dropped_q;

   assign light[0] = ew_str_light;
   assign light[1] = ew_left_light;
   assign light[2] = ns_light;
   assign arrive   = {ns_arrive, ew_left_arrive, ew_str_arrive};

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      depart  = '0;
      drop    = '0;
      for (int i = 0; i < NL; i++) begin
         state_d[i] = state_q[i];
         ctr_d[i]   = ctr_q[i];
         count_d[i] = count_q[i];
         case (state_q[i])
            STOP: begin
               if (light[i] == green) begin
                  ctr_d[i]   = 4'd0;
                  state_d[i] = (START_DELAY == 0) ? FLOW : START;
               end
            end
            START: begin
               if (light[i] != green) begin
                  state_d[i] = STOP;
               end else begin
                  ctr_d[i] = ctr_q[i] + 4'd1;
                  // FLOW on this edge makes the first departure land START_DELAY greens after the first
                  if (int'(ctr_q[i]) + 1 >= START_DELAY - 1)
                     state_d[i] = FLOW;
               end
            end
            FLOW: begin
               if (light[i] != green)
                  state_d[i] = STOP;
               else
                  depart[i] = (count_q[i] != '0);
            end
            default: state_d[i] = STOP;
         endcase

         if (arrive[i] && !depart[i]) begin
            if (count_q[i] == QW'(QDEPTH))
               drop[i] = 1'b1;
            else
               count_d[i] = count_q[i] + 1'b1;
         end else if (!arrive[i] && depart[i]) begin
            count_d[i] = count_q[i] - 1'b1;
         end
      end
      total_d = total_q + 16'(depart[0]) + 16'(depart[1]) + 16'(depart[2]);
   end

   // NOTE: state registers use non-blocking assignments so every lane sees the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NL; i++) begin
            state_q[i] <= STOP;
            ctr_q[i]   <= 4'd0;
            count_q[i] <= '0;
         end
         total_q   <= 16'd0;
         dropped_q <= '0;
      end else begin
         for (int i = 0; i < NL; i++) begin
            state_q[i] <= state_d[i];
            ctr_q[i]   <= ctr_d[i];
            count_q[i] <= count_d[i];
         end
         total_q   <= total_d;
         dropped_q <= dropped_q | drop;
      end
   end

   assign ew_str_count   = count_q[0];
   assign ew_left_count  = count_q[1];
   assign ns_count       = count_q[2];
   assign ew_str_sensor  = (count_q[0] != '0);
   assign ew_left_sensor = (count_q[1] != '0);
   assign ns_sensor      = (count_q[2] != '0);
   assign departed_total = total_q;
   assign dropped        = dropped_q;

`ifdef TLC_SAFETY_CHECK_EN
   colors         prev_q [NL];
   logic [1:0]    safety_q;
   logic          conflict;
   logic          illegal_seq;

   always_comb begin
      conflict = (light[0] != red && light[1] != red) ||
                 (light[0] != red && light[2] != red) ||
                 (light[1] != red && light[2] != red);
      illegal_seq = 1'b0;
      for (int i = 0; i < NL; i++) begin
         if ((prev_q[i] == green && light[i] == red) ||
             (prev_q[i] == yellow && light[i] == green))
            illegal_seq = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NL; i++)
            prev_q[i] <= red;
         safety_q <= 2'b00;
      end else begin
         for (int i = 0; i < NL; i++)
            prev_q[i] <= light[i];
         safety_q <= safety_q | {illegal_seq, conflict};
      end
   end

   assign safety_err = safety_q;
`else
   assign safety_err = 2'b00;
`endif

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed bench for intersection_traffic_model: queues, start delay, overflow, reset and safety flags.

module tb_intersection_traffic_model;
   import light_package::*;

   logic        clk;
   logic        reset;
   logic        ew_str_arrive, ew_left_arrive, ns_arrive;
   colors       ew_str_light, ew_left_light, ns_light;
   logic        ew_str_sensor, ew_left_sensor, ns_sensor;
   logic [3:0]  ew_str_count, ew_left_count, ns_count;
   logic [15:0] departed_total;
   logic [2:0]  dropped;
   logic [1:0]  safety_err;

   int n_checks = 0;
   int n_fail   = 0;

   intersection_traffic_model #(.QDEPTH(15), .START_DELAY(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .ew_str_arrive  (ew_str_arrive),
      .ew_left_arrive (ew_left_arrive),
      .ns_arrive      (ns_arrive),
      .ew_str_light   (ew_str_light),
      .ew_left_light  (ew_left_light),
      .ns_light       (ns_light),
      .ew_str_sensor  (ew_str_sensor),
      .ew_left_sensor (ew_left_sensor),
      .ns_sensor      (ns_sensor),
      .ew_str_count   (ew_str_count),
      .ew_left_count  (ew_left_count),
      .ns_count       (ns_count),
      .departed_total (departed_total),
      .dropped        (dropped),
      .safety_err     (safety_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ew_str_arrive  = 1'b0;
      ew_left_arrive = 1'b0;
      ns_arrive      = 1'b0;
      ew_str_light   = red;
      ew_left_light  = red;
      ns_light       = red;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({ew_str_count, ew_left_count, ns_count} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_counts got %h want 000", {ew_str_count, ew_left_count, ns_count});
      end
      n_checks++;
      if ({ew_str_sensor, ew_left_sensor, ns_sensor} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_sensors got %b want 000", {ew_str_sensor, ew_left_sensor, ns_sensor});
      end
      n_checks++;
      if ({departed_total, dropped, safety_err} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_flags total %0d dropped %b safety %b want 0", departed_total, dropped, safety_err);
      end
      reset = 1'b0;
   endtask

   task automatic test_arrivals();
      ew_str_arrive = 1'b1;
      n_checks++;
      if (ew_str_sensor !== 1'b0) begin
         n_fail++;
         $display("FAIL arrive_sensor_before got %b want 0", ew_str_sensor);
      end
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) begin
            tick();
            ew_str_arrive = 1'b0;
         end else begin
            tick();
         end
         n_checks++;
         if (ew_str_count !== 4'(i) || ew_str_sensor !== 1'b1) begin
            n_fail++;
            $display("FAIL arrive_count_%0d got count %0d sensor %b want %0d/1", i, ew_str_count, ew_str_sensor, i);
         end
      end
      tick();
      n_checks++;
      if (ew_str_count !== 4'd3 || departed_total !== 16'd0) begin
         n_fail++;
         $display("FAIL arrive_hold got count %0d total %0d want 3/0", ew_str_count, departed_total);
      end
   endtask

   task automatic test_green_departures();
      logic [3:0]  exp_cnt [6] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
      logic [15:0] exp_tot [6] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3};
      ew_str_light = green;
      for (int g = 0; g < 6; g++) begin
         tick();
         n_checks++;
         if (ew_str_count !== exp_cnt[g] || departed_total !== exp_tot[g]) begin
            n_fail++;
            $display("FAIL green_cycle_%0d got count %0d total %0d want %0d/%0d",
                     g + 1, ew_str_count, departed_total, exp_cnt[g], exp_tot[g]);
         end
      end
      n_checks++;
      if (ew_str_sensor !== 1'b0) begin
         n_fail++;
         $display("FAIL green_sensor_empty got %b want 0", ew_str_sensor);
      end
      ew_str_light = yellow;
      tick();
      ew_str_light = red;
      tick();
   endtask

   task automatic test_overflow();
      apply_reset();
      ns_arrive = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 15) begin
            n_checks++;
            if (ns_count !== 4'd15 || dropped !== 3'b000) begin
               n_fail++;
               $display("FAIL overflow_at_full got count %0d dropped %b want 15/000", ns_count, dropped);
            end
         end
         if (i == 16) begin
            n_checks++;
            if (ns_count !== 4'd15 || dropped !== 3'b100) begin
               n_fail++;
               $display("FAIL overflow_first_drop got count %0d dropped %b want 15/100", ns_count, dropped);
            end
         end
      end
      ns_arrive = 1'b0;
      tick();
      n_checks++;
      if (ns_count !== 4'd15 || dropped !== 3'b100 || ns_sensor !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_final got count %0d dropped %b sensor %b want 15/100/1", ns_count, dropped, ns_sensor);
      end
   endtask

   task automatic test_flow_hold();
      logic [3:0] exp_cnt [5] = '{4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
      apply_reset();
      ew_left_arrive = 1'b1;
      tick();
      tick();
      tick();
      ew_left_light = green;
      for (int g = 0; g < 5; g++) begin
         tick();
         n_checks++;
         if (ew_left_count !== exp_cnt[g]) begin
            n_fail++;
            $display("FAIL flow_hold_cycle_%0d got %0d want %0d", g + 1, ew_left_count, exp_cnt[g]);
         end
      end
      ew_left_light = yellow;
      tick();
      n_checks++;
      if (ew_left_count !== 4'd6 || departed_total !== 16'd3) begin
         n_fail++;
         $display("FAIL flow_yellow got count %0d total %0d want 6/3", ew_left_count, departed_total);
      end
      ew_left_arrive = 1'b0;
      ew_left_light  = red;
      tick();
      n_checks++;
      if (ew_left_count !== 4'd6) begin
         n_fail++;
         $display("FAIL flow_red_hold got %0d want 6", ew_left_count);
      end
   endtask

   task automatic test_reset_mid_flow();
      logic [3:0] exp_cnt [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
      apply_reset();
      ew_left_arrive = 1'b1;
      repeat (4) tick();
      ew_left_arrive = 1'b0;
      ew_left_light  = green;
      tick();
      tick();
      n_checks++;
      if (ew_left_count !== 4'd4) begin
         n_fail++;
         $display("FAIL midflow_setup got %0d want 4", ew_left_count);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (ew_left_count !== 4'd0 || ew_left_sensor !== 1'b0 || departed_total !== 16'd0 || dropped !== 3'b000) begin
         n_fail++;
         $display("FAIL midflow_async_reset got count %0d sensor %b total %0d dropped %b want 0",
                  ew_left_count, ew_left_sensor, departed_total, dropped);
      end
      tick();
      reset          = 1'b0;
      ew_left_arrive = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 1) ew_left_arrive = 1'b0;
         n_checks++;
         if (ew_left_count !== exp_cnt[k]) begin
            n_fail++;
            $display("FAIL midflow_redelay_%0d got %0d want %0d", k, ew_left_count, exp_cnt[k]);
         end
      end
      ew_left_light = yellow;
      tick();
      ew_left_light = red;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_tot [4] = '{16'd0, 16'd0, 16'd3, 16'd6};
      apply_reset();
      ew_str_arrive  = 1'b1;
      ew_left_arrive = 1'b1;
      ns_arrive      = 1'b1;
      tick();
      tick();
      idle_inputs();
      ew_str_light  = green;
      ew_left_light = green;
      ns_light      = green;
      for (int g = 0; g < 4; g++) begin
         tick();
         n_checks++;
         if (departed_total !== exp_tot[g]) begin
            n_fail++;
            $display("FAIL multi_lane_total_%0d got %0d want %0d", g + 1, departed_total, exp_tot[g]);
         end
      end
      n_checks++;
      if ({ew_str_count, ew_left_count, ns_count} !== 12'h000) begin
         n_fail++;
         $display("FAIL multi_lane_drain got %h want 000", {ew_str_count, ew_left_count, ns_count});
      end
   endtask

   task automatic test_safety();
      logic [1:0] exp_conf;
      logic [1:0] exp_both;
`ifdef TLC_SAFETY_CHECK_EN
      exp_conf = 2'b01;
      exp_both = 2'b11;
`else
      exp_conf = 2'b00;
      exp_both = 2'b00;
`endif
      apply_reset();
      ew_str_light = green;
      ns_light     = green;
      tick();
      n_checks++;
      if (safety_err !== exp_conf) begin
         n_fail++;
         $display("FAIL safety_conflict got %b want %b", safety_err, exp_conf);
      end
      ew_str_light = yellow;
      ns_light     = yellow;
      tick();
      ew_str_light = red;
      ns_light     = red;
      tick();
      ew_left_light = green;
      tick();
      n_checks++;
      if (safety_err !== exp_conf) begin
         n_fail++;
         $display("FAIL safety_legal_seq got %b want %b", safety_err, exp_conf);
      end
      ew_left_light = red;
      tick();
      n_checks++;
      if (safety_err !== exp_both) begin
         n_fail++;
         $display("FAIL safety_green_to_red got %b want %b", safety_err, exp_both);
      end
      tick();
      tick();
      n_checks++;
      if (safety_err !== exp_both) begin
         n_fail++;
         $display("FAIL safety_sticky got %b want %b", safety_err, exp_both);
      end
      apply_reset();
      n_checks++;
      if (safety_err !== 2'b00) begin
         n_fail++;
         $display("FAIL safety_cleared got %b want 00", safety_err);
      end
   endtask

   initial begin
      test_reset();
      test_arrivals();
      test_green_departures();
      test_overflow();
      test_flow_hold();
      test_reset_mid_flow();
      test_back_to_back();
      test_safety();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
